// File: rtl/program_counter_unit_if.sv
// Control/data bundle between the instruction decoders and program_counter_unit.
// The decoder side uses the master modport and the PC unit uses the slave modport.
interface program_counter_unit_if #(
   parameter int unsigned PC_WIDTH = 64
);
   logic [32:0]         controlword;
   logic [PC_WIDTH-1:0] constant;
   logic [PC_WIDTH-1:0] reg_a;
   logic [3:0]          alu_flags;
   logic [PC_WIDTH-1:0] pc;
   logic [4:0]          status;
   logic [1:0]          state;
   logic [PC_WIDTH-1:0] databus_out;
   logic                databus_out_en;
   logic [31:0]         branch_count;

   modport master (
      output controlword, constant, reg_a, alu_flags,
      input  pc, status, state, databus_out, databus_out_en, branch_count
   );

   modport slave (
      input  controlword, constant, reg_a, alu_flags,
      output pc, status, state, databus_out, databus_out_en, branch_count
   );
endinterface

// File: rtl/program_counter_unit.sv
// Program counter, status and control-state registers driven by the decoder control word.
// Optional taken-offset counter is built when PC_BRANCH_COUNT_EN is defined.
module program_counter_unit #(
   parameter int unsigned         PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
   input  logic                   clock,
   input  logic                   reset,
   program_counter_unit_if.slave  bus
);
   localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(3'd4);

   logic                pc_databus_en_s;
   logic [1:0]          pc_fs_s;
   logic                pc_in_sel_s;
   logic                status_load_s;
   logic [1:0]          next_state_s;
   logic [PC_WIDTH-1:0] op_s;
   logic                unused_cw_s;

   logic [PC_WIDTH-1:0] pc_d, pc_q;
   logic [4:0]          status_d, status_q;
   logic [1:0]          state_d, state_q;

   assign pc_databus_en_s = bus.controlword[6];
   assign pc_fs_s         = bus.controlword[5:4];
   assign pc_in_sel_s     = bus.controlword[3];
   assign status_load_s   = bus.controlword[2];
   assign next_state_s    = bus.controlword[1:0];
   assign unused_cw_s     = ^bus.controlword[32:7];

   // Next-state logic for pc, status and control state
   always_comb begin
      op_s     = pc_in_sel_s ? bus.constant : bus.reg_a;
      pc_d     = pc_q;
      status_d = status_q;
      state_d  = next_state_s;
      case (pc_fs_s)
         2'b00:   pc_d = pc_q;
         2'b01:   pc_d = pc_q + PC_INC;
         2'b10:   pc_d = op_s;
         2'b11:   pc_d = pc_q + (op_s << 2);
         default: pc_d = pc_q;
      endcase
      // flags_valid is sticky: once any load happens it stays set until reset
      if (status_load_s) begin
         status_d = {bus.alu_flags, 1'b1};
      end else begin
         status_d = status_q;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         status_q <= 5'b00000;
         state_q  <= 2'b00;
      end else begin
         pc_q     <= pc_d;
         status_q <= status_d;
         state_q  <= state_d;
      end
   end

`ifdef PC_BRANCH_COUNT_EN
   logic [31:0] branch_count_d, branch_count_q;

   // Saturating count of relative-branch cycles
   always_comb begin
      branch_count_d = branch_count_q;
      if ((pc_fs_s == 2'b11) && (branch_count_q != 32'hFFFF_FFFF)) begin
         branch_count_d = branch_count_q + 32'd1;
      end else begin
         branch_count_d = branch_count_q;
      end
   end

   // Branch counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         branch_count_q <= 32'd0;
      end else begin
         branch_count_q <= branch_count_d;
      end
   end

   assign bus.branch_count = branch_count_q;
`else
   assign bus.branch_count = 32'h0000_0000;
`endif

   assign bus.pc             = pc_q;
   assign bus.status         = status_q;
   assign bus.state          = state_q;
   assign bus.databus_out    = pc_q + PC_INC;
   assign bus.databus_out_en = pc_databus_en_s;
endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Execution-side consumer of the 33-bit control word produced by the instruction decoders, including the conditional-branch decoder. Holds the program counter, the status register and the control-state register. Each clock it applies the control word's PC function, status-load and next-state fields. It also returns the registered status and state values to the decoders, and drives the PC link value onto the datapath bus when enabled.

## Interface
Parameters:
- PC_WIDTH, 64, width of program counter and all address arithmetic.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers immediately.
- controlword  input  33  decoder output. Fields used: [6] pc_databus_en, [5:4] pc_fs, [3] pc_in_sel, [2] status_load, [1:0] next_state. Bits [32:7] are ignored.
- constant  input  64  sign-extended immediate from the decoder.
- reg_a  input  64  register-file port A data.
- alu_flags  input  4  live ALU flags {z,c,n,v}.
- pc  output  64  current program counter.
- status  output  5  [4:1] registered {z,c,n,v}; [0] flags_valid.
- state  output  2  current control state, fed back to decoders.
- databus_out  output  64  link value pc+4.
- databus_out_en  output  1  equals controlword[6], combinational.
- branch_count  output  32  taken-offset counter; see Configuration.

## Operation
- Operand select: `op = pc_in_sel ? constant : reg_a`.
- PC function, applied at each rising edge:
  - pc_fs=00: hold.
  - pc_fs=01: pc <= pc + 4.
  - pc_fs=10: pc <= op (absolute load, e.g. BR).
  - pc_fs=11: pc <= pc + (op << 2) (relative branch).
- All PC arithmetic is modulo 2^PC_WIDTH. Wrap-around is silent, no flag.
- The shift for pc_fs=11 discards op[63:62]. A negative op produces a backward target.
- Status register:
  - When status_load=1: status[4:1] <= alu_flags and status[0] <= 1.
  - Otherwise the register holds.
  - status[0] stays 1 until reset.
- State register: state <= next_state every cycle, unconditionally. Encodings 00..11 are all legal; no decoding is done here.
- databus_out = pc + 4, computed combinationally from the registered pc. It is valid regardless of the enable.
- The PC, status and state updates are independent. All three can occur in the same cycle.
- A status load in cycle N is visible on `status` in cycle N+1. A branch decoder therefore evaluates flags loaded by the previous instruction, never the current one.

## Timing
- Reset values: pc=RESET_PC, status=5'b00000, state=2'b00, branch_count=0. databus_out then reads RESET_PC+4.
- Reset asserted mid-cycle clears outputs within the same cycle, with no clock edge needed. The first update after deassertion uses the control word present at the next rising edge.
- Latency:
  - 1 cycle for pc, status and state: input at edge N, output after edge N.
  - 0 cycles for databus_out_en.
  - 0 cycles for databus_out, relative to pc.
- There is no handshake. The control word must be stable before each rising edge.
- A control word applied in the same cycle as a reset deassertion edge is ignored (reset dominates).

## Configuration
- PC_BRANCH_COUNT_EN:
  - Defined: branch_count increments by 1 on every rising edge where pc_fs=11, saturating at 32'hFFFF_FFFF. It clears on reset.
  - Undefined: no counter logic is built, and branch_count is tied to 32'h0.
  - PC and status behaviour is identical either way.

## Test plan
- Reset then hold: assert reset with pc_fs=00 → pc=0, status=0, state=0. Deassert and run 3 clocks with pc_fs=01 → pc=0x0C, databus_out=0x10.
- Relative branch: pc=0x100, pc_fs=11, pc_in_sel=1, constant=-2 (0xFFFF_FFFF_FFFF_FFFE) → pc=0xF8 next cycle. With PC_BRANCH_COUNT_EN defined, branch_count=1.
- Absolute load: pc_in_sel=0, reg_a=0xDEAD_BEE0, pc_fs=10 → pc=0xDEAD_BEE0. Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, pc_fs=01 → pc=0.
- Status load: alu_flags=4'b1010, status_load=1 → status=5'b10101 next cycle. Then status_load=0 with alu_flags=0 → status unchanged.
- Simultaneous events and async reset: a single edge with pc_fs=11, status_load=1, next_state=2'b10 updates pc, status and state together. Asserting reset between edges → all outputs return to reset values before the next edge.
